tt_mux_slot_ctrl: RTL
=====================

# tt_mux_slot_ctrl

Parametrised project-slot controller for the muxperiment harness. It generalises the fixed single-project pin wrapper to NUM_PROJ wrapped projects sharing one set of chip pins. It accepts select requests over a valid/ready handshake and sequences every project switch as: drain the old project, reset the new one, then run. Each project sees its own packed input bus and only the active project reaches the chip outputs.

## Interface
Parameters:
- NUM_PROJ, 8: number of project slots, 2..32.
- IW_W, 18: per-project packed input width; bit 0 = clk, bit 1 = rst_n, bits IW_W-1:2 = user inputs.
- OW_W, 24: per-project packed output width.
- RST_CYCLES, 4: cycles the new project is held in reset, 1..255.
- DRAIN_CYCLES, 2: cycles outputs are forced to 0 before switching, 1..15.
- SEL_W (localparam): $clog2(NUM_PROJ+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- user_rst_n  in  1  user reset from pins; forwarded to the active project in RUN.
- user_in  in  IW_W-2  user inputs (ui_in/uio_in).
- sel_valid  in  1  select request valid.
- sel_id  in  SEL_W  requested slot; a value >= NUM_PROJ means "none".
- sel_ready  out  1  request accepted when sel_valid && sel_ready.
- active_id  out  SEL_W  current slot; NUM_PROJ when none.
- busy  out  1  high in DRAIN or RESET.
- ena  out  NUM_PROJ  one-hot project enable.
- iw  out  NUM_PROJ*IW_W  packed per-project input buses; slot k occupies bits [k*IW_W +: IW_W].
- ow  in  NUM_PROJ*OW_W  packed per-project output buses.
- ow_out  out  OW_W  muxed output to pins ({uio_oe, uio_out, uo_out}).

## Operation
- FSM states (tt_mux_pkg::state_t): IDLE, DRAIN, RESET, RUN.
- IDLE: no slot active; ena=0; ow_out=0; sel_ready=1.
  - Accepting a valid slot goes to RESET.
  - Accepting "none" stays in IDLE.
- RUN: ena[active]=1.
  - Active project rst_n = user_rst_n; active project clk bit = gated clk.
  - ow_out follows ow of the active slot.
  - sel_ready=1. Any accept, including the same slot (forced re-reset) or "none", goes to DRAIN.
- DRAIN: ow_out=0 and the old slot keeps ena for DRAIN_CYCLES. sel_ready=0.
  - Next state is RESET for a valid pending id, IDLE for "none".
- RESET: ena[new]=1 with project rst_n=0 and clock running, for RST_CYCLES. ow_out=0; sel_ready=0. Then RUN, with active_id updated on entry.
- Inactive slots: iw clk bit = 0, rst_n bit = 0, user bits = 0.
- The accepted sel_id is latched on the handshake. sel_valid while sel_ready=0 is ignored; the requester must hold it.
- Reset value of every output: sel_ready=1, active_id=NUM_PROJ, busy=0, ena=0, iw=0, ow_out=0. State = IDLE.
- rst_n asserted mid-DRAIN or mid-RESET aborts immediately to the reset values.

## Timing
- Handshake on cycle T gives: DRAIN at T+1 (from RUN) or RESET at T+1 (from IDLE).
- Switch latency from RUN: DRAIN_CYCLES + RST_CYCLES cycles to RUN. From IDLE: RST_CYCLES cycles.
- Drain and reset counters are 8-bit and saturate to avoid wrap. Each reloads on state entry.
- Project clock gating uses a glitch-free latch-based gate and changes only while the clk low phase is active.

## Configuration
- MUX_OUT_REG_EN defined: ow_out is registered, giving 1-cycle latency from the active slot's ow. The zero-forcing in DRAIN/RESET applies to the register input.
- Undefined: ow_out is a combinational mux of ow gated by (state==RUN), with zero latency.
- All other behaviour is identical in both builds.

## Structure
- Package tt_mux_pkg contains:
  - state_t enum;
  - constants IW_CLK_BIT=0 and IW_RST_BIT=1;
  - the counter width constant CNT_W=8.
- Sub-module tt_mux_clk_gate: latch plus AND, one instance per slot, with enable = ena[k].
- Everything else lives in tt_mux_slot_ctrl.

## Test plan
- Reset, then select slot 3 from IDLE (RST_CYCLES=4) -> iw slot 3 rst_n bit low for 4 cycles, then RUN. active_id=3; ow_out tracks ow slot 3 (1-cycle lag with MUX_OUT_REG_EN).
- From RUN slot 3, select slot 5 -> ow_out=0 for 2 drain cycles, slot 3 ena drops, slot 5 reset for 4 cycles, then RUN. busy high for exactly 6 cycles.
- Hold sel_valid with id 1 during busy -> ignored until sel_ready=1, then accepted once.
- Select id=NUM_PROJ from RUN -> drain, then IDLE. ena=0; active_id=NUM_PROJ; ow_out=0.
- Reselect slot 3 while running 3 -> full drain plus re-reset sequence.
- Assert rst_n during the RESET phase -> all outputs reach reset values asynchronously and state is IDLE.

Source files
------------

// File: rtl/tt_mux_pkg.sv
// tt_mux_pkg: shared FSM state type and bit-position constants for the project-slot mux.
package tt_mux_pkg;
   typedef enum logic [1:0] {IDLE, DRAIN, RESET, RUN} state_t;
   localparam int IW_CLK_BIT = 0;
   localparam int IW_RST_BIT = 1;
   localparam int CNT_W = 8;
endpackage

// File: rtl/tt_mux_clk_gate.sv
// tt_mux_clk_gate: glitch-free latch-plus-AND clock gate; the enable is only sampled while clk is low.
module tt_mux_clk_gate (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic gclk
);
   logic en_l;
   always_latch
      if (!rst_n) en_l = 1'b0;
      else if (!clk) en_l = en;
   assign gclk = clk & en_l;
endmodule

// File: rtl/tt_mux_slot_ctrl.sv
// tt_mux_slot_ctrl: multiplexes NUM_PROJ wrapped projects onto one pin set with drain/reset/run sequencing.
// Define MUX_OUT_REG_EN to register ow_out (1-cycle latency); otherwise ow_out is combinational.
module tt_mux_slot_ctrl
   import tt_mux_pkg::*;
#(
   parameter int NUM_PROJ     = 8,
   parameter int IW_W         = 18,
   parameter int OW_W         = 24,
   parameter int RST_CYCLES   = 4,
   parameter int DRAIN_CYCLES = 2,
   localparam int SEL_W       = $clog2(NUM_PROJ + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     user_rst_n,
   input  logic [IW_W-3:0]          user_in,
   input  logic                     sel_valid,
   input  logic [SEL_W-1:0]         sel_id,
   output logic                     sel_ready,
   output logic [SEL_W-1:0]         active_id,
   output logic                     busy,
   output logic [NUM_PROJ-1:0]      ena,
   output logic [NUM_PROJ*IW_W-1:0] iw,
   input  logic [NUM_PROJ*OW_W-1:0] ow,
   output logic [OW_W-1:0]          ow_out
);
   localparam logic [SEL_W-1:0] NONE = SEL_W'(NUM_PROJ);
   localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRN_LD = CNT_W'(DRAIN_CYCLES - 1);
   state_t state;
   logic [CNT_W-1:0] cnt;
   logic [SEL_W-1:0] pend;
   logic [NUM_PROJ-1:0] gclk;
   logic [OW_W-1:0] sel_ow;
   logic run;
   assign run = state == RUN;
   // Counters only step down while nonzero, so they never wrap.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         pend      <= NONE;
         active_id <= NONE;
         busy      <= 1'b0;
         sel_ready <= 1'b1;
         ena       <= '0;
      end else begin
         case (state)
            IDLE:
               if (sel_valid && sel_id < NONE) begin
                  state     <= RESET;
                  pend      <= sel_id;
                  cnt       <= RST_LD;
                  ena       <= NUM_PROJ'(1) << sel_id;
                  busy      <= 1'b1;
                  sel_ready <= 1'b0;
               end
            RUN:
               if (sel_valid) begin
                  state     <= DRAIN;
                  pend      <= sel_id;
                  cnt       <= DRN_LD;
                  busy      <= 1'b1;
                  sel_ready <= 1'b0;
               end
            DRAIN:
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
               else if (pend < NONE) begin
                  state <= RESET;
                  cnt   <= RST_LD;
                  ena   <= NUM_PROJ'(1) << pend;
               end else begin
                  state     <= IDLE;
                  ena       <= '0;
                  active_id <= NONE;
                  busy      <= 1'b0;
                  sel_ready <= 1'b1;
               end
            default:
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
               else begin
                  state     <= RUN;
                  active_id <= pend;
                  busy      <= 1'b0;
                  sel_ready <= 1'b1;
               end
         endcase
      end
   for (genvar k = 0; k < NUM_PROJ; k++) begin : g_slot
      tt_mux_clk_gate u_gate (.clk(clk), .rst_n(rst_n), .en(ena[k]), .gclk(gclk[k]));
      assign iw[k*IW_W + IW_CLK_BIT] = gclk[k];
      assign iw[k*IW_W + IW_RST_BIT] = ena[k] & run & user_rst_n;
      assign iw[k*IW_W + 2 +: IW_W-2] = ena[k] ? user_in : '0;
   end
   always_comb begin
      sel_ow = '0;
      for (int i = 0; i < NUM_PROJ; i++) sel_ow = sel_ow | (ena[i] ? ow[i*OW_W +: OW_W] : '0);
   end
`ifdef MUX_OUT_REG_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ow_out <= '0;
      else ow_out <= run ? sel_ow : '0;
`else
   assign ow_out = run ? sel_ow : '0;
`endif
endmodule
